// File: rtl/jk_fsm_pkg.sv
// Shared definitions for the JK channel bank: the ON/OFF state encoding and
// the next-state function of one channel.
package jk_fsm_pkg;

    typedef enum logic {
        ST_OFF = 1'b0,
        ST_ON  = 1'b1
    } jk_state_e;

    // Plain JK next-state rule: j sets, k clears, both toggle, neither holds.
    function automatic jk_state_e jk_next(input jk_state_e state, input logic j, input logic k);
        jk_state_e nxt;
        case ({j, k})
            2'b00:   nxt = state;
            2'b10:   nxt = ST_ON;
            2'b01:   nxt = ST_OFF;
            2'b11:   nxt = (state == ST_ON) ? ST_OFF : ST_ON;
            default: nxt = state;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/jk_fsm_cell.sv
// One ON/OFF channel: a two-state Moore FSM guarded by a dwell counter that
// locks the channel for DWELL cycles after every transition. Requests seen
// while locked (or while en=0) are dropped. With JK_FSM_BANK_EVT_EN defined
// the cell also exposes its rise/fall transition strobes for the top level.
module jk_fsm_cell
    import jk_fsm_pkg::*;
#(
    parameter int unsigned DWELL = 3
) (
    input  logic sys_clk_i,
    input  logic sys_rst_n_i,
    input  logic en_i,
    input  logic j_i,
    input  logic k_i,
    output logic out_o,
    output logic busy_o
`ifdef JK_FSM_BANK_EVT_EN
    ,
    output logic rise_o,
    output logic fall_o
`endif
);

    // A DWELL of zero still needs a one-bit counter so the logic stays uniform.
    localparam int unsigned CW = (DWELL == 0) ? 1 : $clog2(DWELL + 1);
    localparam logic [CW-1:0] DWELL_LD = CW'(DWELL);
    localparam logic [CW-1:0] CNT_ZERO = {CW{1'b0}};
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    jk_state_e     state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          busy_q, busy_d;
    logic          ok_s;
    logic          trans_s;

    // Next state and dwell countdown; the countdown runs regardless of en.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        ok_s    = en_i && (cnt_q == CNT_ZERO);
        if (ok_s) begin
            state_d = jk_next(state_q, j_i, k_i);
        end else begin
            state_d = state_q;
        end
        trans_s = (state_d != state_q);
        if (trans_s) begin
            cnt_d = DWELL_LD;
        end else if (cnt_q != CNT_ZERO) begin
            cnt_d = cnt_q - CNT_ONE;
        end else begin
            cnt_d = CNT_ZERO;
        end
        busy_d = (cnt_d != CNT_ZERO);
    end

    // State, counter and busy flag registers; reset also aborts any dwell.
    always_ff @(posedge sys_clk_i) begin
        if (!sys_rst_n_i) begin
            state_q <= ST_OFF;
            cnt_q   <= CNT_ZERO;
            busy_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            busy_q  <= busy_d;
        end
    end

    assign out_o  = (state_q == ST_ON);
    assign busy_o = busy_q;

`ifdef JK_FSM_BANK_EVT_EN
    // Transition strobes for the edge about to happen; the top registers them.
    assign rise_o = trans_s && (state_d == ST_ON);
    assign fall_o = trans_s && (state_d == ST_OFF);
`endif

endmodule

// File: rtl/jk_fsm_bank.sv
// Bank of CH independent JK ON/OFF channels with per-channel dwell lock.
// Optional feature macro JK_FSM_BANK_EVT_EN adds registered rise/fall pulses
// and a saturating 16-bit count of all transitions across the bank.
module jk_fsm_bank
    import jk_fsm_pkg::*;
#(
    parameter int unsigned CH    = 4,
    parameter int unsigned DWELL = 3
) (
    input  logic          sys_clk,
    input  logic          sys_rst_n,
    input  logic          en,
    input  logic [CH-1:0] j,
    input  logic [CH-1:0] k,
    output logic [CH-1:0] out,
    output logic [CH-1:0] busy
`ifdef JK_FSM_BANK_EVT_EN
    ,
    output logic [CH-1:0] rise,
    output logic [CH-1:0] fall,
    output logic [15:0]   evt_cnt
`endif
);

`ifdef JK_FSM_BANK_EVT_EN
    logic [CH-1:0] rise_s;
    logic [CH-1:0] fall_s;
`endif

    for (genvar g = 0; g < CH; g++) begin : g_cell
        jk_fsm_cell #(
            .DWELL(DWELL)
        ) u_cell (
            .sys_clk_i  (sys_clk),
            .sys_rst_n_i(sys_rst_n),
            .en_i       (en),
            .j_i        (j[g]),
            .k_i        (k[g]),
            .out_o      (out[g]),
            .busy_o     (busy[g])
`ifdef JK_FSM_BANK_EVT_EN
            ,
            .rise_o     (rise_s[g]),
            .fall_o     (fall_s[g])
`endif
        );
    end

`ifdef JK_FSM_BANK_EVT_EN
    localparam int unsigned PW = $clog2(CH + 1);

    logic [PW-1:0] pop_s;
    logic [16:0]   sum_s;
    logic [15:0]   evt_d;
    logic [15:0]   evt_q;
    logic [CH-1:0] rise_q;
    logic [CH-1:0] fall_q;

    // Count channels transitioning on this edge and saturate the running total.
    always_comb begin
        pop_s = {PW{1'b0}};
        for (int i = 0; i < CH; i++) begin
            pop_s = pop_s + PW'(rise_s[i] | fall_s[i]);
        end
        sum_s = {1'b0, evt_q} + 17'(pop_s);
        if (sum_s > 17'h0FFFF) begin
            evt_d = 16'hFFFF;
        end else begin
            evt_d = sum_s[15:0];
        end
    end

    // Event registers: one-cycle pulses aligned with the new out value.
    always_ff @(posedge sys_clk) begin
        if (!sys_rst_n) begin
            rise_q <= {CH{1'b0}};
            fall_q <= {CH{1'b0}};
            evt_q  <= 16'h0000;
        end else begin
            rise_q <= rise_s;
            fall_q <= fall_s;
            evt_q  <= evt_d;
        end
    end

    assign rise    = rise_q;
    assign fall    = fall_q;
    assign evt_cnt = evt_q;
`endif

endmodule

// File: tb/tb_jk_fsm_bank.sv
// Self-checking bench for jk_fsm_bank (CH=4, DWELL=3). A behavioural model of
// the channel rules is checked against the DUT on every falling edge, and
// hand-computed literals pin the directed scenarios. Event outputs are
// checked when JK_FSM_BANK_EVT_EN is defined.
`timescale 1ns/1ps
module tb_jk_fsm_bank;

    localparam int CH    = 4;
    localparam int DWELL = 3;

    logic          sys_clk = 1'b0;
    logic          sys_rst_n;
    logic          en;
    logic [CH-1:0] j;
    logic [CH-1:0] k;
    logic [CH-1:0] out;
    logic [CH-1:0] busy;
`ifdef JK_FSM_BANK_EVT_EN
    logic [CH-1:0] rise;
    logic [CH-1:0] fall;
    logic [15:0]   evt_cnt;
`endif

    jk_fsm_bank #(
        .CH   (CH),
        .DWELL(DWELL)
    ) dut (
        .sys_clk  (sys_clk),
        .sys_rst_n(sys_rst_n),
        .en       (en),
        .j        (j),
        .k        (k),
        .out      (out),
        .busy     (busy)
`ifdef JK_FSM_BANK_EVT_EN
        ,
        .rise     (rise),
        .fall     (fall),
        .evt_cnt  (evt_cnt)
`endif
    );

    always #5 sys_clk = ~sys_clk;

    int n_cmp = 0;
    int n_bad = 0;
    bit chk_en = 1'b0;

    // Behavioural model: per-channel on/off flag and remaining lock cycles.
    logic [CH-1:0] m_on   = '0;
    int            m_lock [CH];
    logic [CH-1:0] m_rise = '0;
    logic [CH-1:0] m_fall = '0;
    int            m_evt  = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [CH-1:0] m_busy();
        logic [CH-1:0] b;
        for (int i = 0; i < CH; i++) b[i] = (m_lock[i] > 0);
        return b;
    endfunction

    // Apply one rising edge of the rules to the model.
    task automatic model_step(input logic r, input logic e, input logic [CH-1:0] jj, input logic [CH-1:0] kk);
        int  changed;
        bit  want;
        changed = 0;
        m_rise  = '0;
        m_fall  = '0;
        if (!r) begin
            m_on  = '0;
            m_evt = 0;
            for (int i = 0; i < CH; i++) m_lock[i] = 0;
        end else begin
            for (int i = 0; i < CH; i++) begin
                want = m_on[i];
                if (e && m_lock[i] == 0) begin
                    if (jj[i] && kk[i]) want = !m_on[i];
                    else if (jj[i])     want = 1'b1;
                    else if (kk[i])     want = 1'b0;
                end
                if (want != m_on[i]) begin
                    m_on[i]   = want;
                    m_lock[i] = DWELL;
                    changed++;
                    if (want) m_rise[i] = 1'b1;
                    else      m_fall[i] = 1'b1;
                end else if (m_lock[i] > 0) begin
                    m_lock[i] = m_lock[i] - 1;
                end
            end
            m_evt = (m_evt + changed > 65535) ? 65535 : m_evt + changed;
        end
    endtask

    // Compare process: DUT against the model on every falling edge.
    always @(negedge sys_clk) begin
        if (chk_en) begin
            check("out", 32'(out), 32'(m_on));
            check("busy", 32'(busy), 32'(m_busy()));
`ifdef JK_FSM_BANK_EVT_EN
            check("rise", 32'(rise), 32'(m_rise));
            check("fall", 32'(fall), 32'(m_fall));
            check("evt_cnt", 32'(evt_cnt), 32'(m_evt));
`endif
        end
    end

    // One clock cycle with the given inputs; returns #1 after the next falling edge.
    task automatic cyc(input logic r, input logic e, input logic [CH-1:0] jj, input logic [CH-1:0] kk);
        sys_rst_n = r;
        en        = e;
        j         = jj;
        k         = kk;
        @(posedge sys_clk);
        model_step(r, e, jj, kk);
        chk_en = 1'b1;
        @(negedge sys_clk);
        #1;
    endtask

    initial begin
        logic [CH-1:0] rj;
        logic [CH-1:0] rk;
        for (int i = 0; i < CH; i++) m_lock[i] = 0;
        sys_rst_n = 1'b0;
        en        = 1'b1;
        j         = '0;
        k         = '0;

        // Reset for two cycles with every turn-on request asserted.
        for (int c = 0; c < 2; c++) begin
            cyc(1'b0, 1'b1, 4'hF, 4'h0);
            check("rst_out", 32'(out), 32'h0);
            check("rst_busy", 32'(busy), 32'h0);
`ifdef JK_FSM_BANK_EVT_EN
            check("rst_evt", 32'(evt_cnt), 32'h0);
`endif
        end

        // Turn-on of channel 0 sampled in cycle t.
        cyc(1'b1, 1'b1, 4'h1, 4'h0);
        check("on_out", 32'(out), 32'h1);
        check("on_busy", 32'(busy), 32'h1);
`ifdef JK_FSM_BANK_EVT_EN
        check("on_rise", 32'(rise), 32'h1);
        check("on_evt", 32'(evt_cnt), 32'h1);
`endif
        // k held from t+1: dropped during dwell, accepted in t+4.
        cyc(1'b1, 1'b1, 4'h0, 4'h1);
        check("dw_out_t2", 32'(out), 32'h1);
        cyc(1'b1, 1'b1, 4'h0, 4'h1);
        check("dw_busy_t3", 32'(busy), 32'h1);
        cyc(1'b1, 1'b1, 4'h0, 4'h1);
        check("dw_out_t4", 32'(out), 32'h1);
        check("dw_busy_t4", 32'(busy), 32'h0);
        cyc(1'b1, 1'b1, 4'h0, 4'h1);
        check("off_out_t5", 32'(out), 32'h0);
`ifdef JK_FSM_BANK_EVT_EN
        check("off_fall_t5", 32'(fall), 32'h1);
        check("off_evt_t5", 32'(evt_cnt), 32'h2);
`endif
        for (int c = 0; c < 4; c++) cyc(1'b1, 1'b1, 4'h0, 4'h0);

        // Toggle channel 1 with j=k held: one toggle every DWELL+1 cycles.
        for (int c = 0; c < 16; c++) begin
            cyc(1'b1, 1'b1, 4'h2, 4'h2);
            if (c == 0) check("tog_first", 32'(out), 32'h2);
            if (c == 3) check("tog_hold", 32'(out), 32'h2);
            if (c == 4) check("tog_second", 32'(out), 32'h0);
        end
        check("tog_end", 32'(out), 32'h0);
`ifdef JK_FSM_BANK_EVT_EN
        check("tog_evt", 32'(evt_cnt), 32'h6);
`endif

        // Enable gating: requests dropped while en=0, then all rise together.
        for (int c = 0; c < 10; c++) cyc(1'b1, 1'b0, 4'hF, 4'h0);
        check("gate_out", 32'(out), 32'h0);
        cyc(1'b1, 1'b1, 4'hF, 4'h0);
        check("all_out", 32'(out), 32'hF);
        check("all_busy", 32'(busy), 32'hF);
`ifdef JK_FSM_BANK_EVT_EN
        check("all_rise", 32'(rise), 32'hF);
        check("all_evt", 32'(evt_cnt), 32'hA);
`endif

        // Reset in the middle of the dwell, then an immediate request.
        cyc(1'b0, 1'b1, 4'h0, 4'h0);
        cyc(1'b0, 1'b1, 4'h0, 4'h0);
        check("mid_rst_out", 32'(out), 32'h0);
        cyc(1'b1, 1'b1, 4'h1, 4'h0);
        check("mid_rel_out", 32'(out), 32'h1);
        check("mid_rel_busy", 32'(busy), 32'h1);
`ifdef JK_FSM_BANK_EVT_EN
        check("mid_rel_rise", 32'(rise), 32'h1);
        check("mid_rel_evt", 32'(evt_cnt), 32'h1);
`endif

        // Mixed pseudo-random traffic, checked by the model only.
        for (int c = 0; c < 60; c++) begin
            rj = CH'($urandom);
            rk = CH'($urandom);
            cyc(1'b1, ($urandom_range(0, 3) != 0), rj, rk);
        end

        chk_en = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
